// File: rtl/bg_spectrum_subtract.sv
// Background-spectrum subtraction for accumulated power spectra.
// One range gate is captured as the background spectrum; every following
// gate has that spectrum subtracted bin-by-bin, saturating at zero.
// Fixed two-cycle latency from din_valid to dout_valid.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no background stored; samples pass through raw
// ST_CAPTURE| writing the current gate into the background RAM, no output
// ST_SUBTRACT| background valid; samples are background-subtracted
module bg_spectrum_subtract #(
    parameter int DATA_W  = 32,
    parameter int FFT_LEN = 256,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bg_load,
    input  logic              din_sof,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_sof,
    output logic              bg_ready,
    output logic              bg_deduct_en,
    output logic              capturing
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_SUBTRACT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_LEN - 1);

    // control state
    state_t            state_q, state_d;
    logic              armed_q, armed_d;
    logic              bg_ready_q, bg_ready_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] bin;
    state_t            mode;
    logic              mem_we;

    // background RAM and its registered read port
    logic [DATA_W-1:0] mem [FFT_LEN];
    logic [DATA_W-1:0] bg_rd_q;

    // stage 1 (aligned with the RAM read)
    logic              s1_valid_q, s1_valid_d;
    logic              s1_sof_q, s1_sof_d;
    logic [DATA_W-1:0] s1_din_q, s1_din_d;
    state_t            s1_mode_q, s1_mode_d;

    // stage 2 (output register)
    logic              dout_valid_q, dout_valid_d;
    logic              dout_sof_q, dout_sof_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              bg_deduct_en_q, bg_deduct_en_d;
    logic              out_ok;

    // Bin index of the current sample: sof forces bin 0, otherwise the counter.
    always_comb begin
        bin   = din_sof ? '0 : cnt_q;
        cnt_d = cnt_q;
        if (din_valid) begin
            cnt_d = bin + ADDR_W'(1);
        end
    end

    // Next-state logic; also decides the mode each sample is processed under.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        bg_ready_d = bg_ready_q;
        mode       = state_q;
        mem_we     = 1'b0;
        case (state_q)
            ST_IDLE, ST_SUBTRACT: begin
                if (bg_load) begin
                    armed_d = 1'b1;
                end
                // Starting a capture consumes the arm, including a bg_load
                // pulse in this very cycle.
                if (din_valid && din_sof && armed_q) begin
                    state_d = ST_CAPTURE;
                    armed_d = 1'b0;
                    mode    = ST_CAPTURE;
                    mem_we  = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (din_valid) begin
                    if (din_sof) begin
                        // Short gate: abandon the capture, the old background
                        // (if any) is still the reference for this new gate.
                        state_d = bg_ready_q ? ST_SUBTRACT : ST_IDLE;
                        mode    = bg_ready_q ? ST_SUBTRACT : ST_IDLE;
                    end else begin
                        mem_we = 1'b1;
                        if (bin == LAST_BIN) begin
                            state_d    = ST_SUBTRACT;
                            bg_ready_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b0;
            bg_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            bg_ready_q <= bg_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    // Simple dual-port RAM, read-first; read is only consumed outside capture.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[bin] <= din;
        end
        if (din_valid) begin
            bg_rd_q <= mem[bin];
        end
    end

    // Stage 1 next values: delay the sample, sof and mode alongside the read.
    always_comb begin
        s1_valid_d = din_valid;
        s1_sof_d   = s1_sof_q;
        s1_din_d   = s1_din_q;
        s1_mode_d  = s1_mode_q;
        if (din_valid) begin
            s1_sof_d  = din_sof;
            s1_din_d  = din;
            s1_mode_d = mode;
        end
    end

    // Stage 2 next values: subtract with saturation, or pass raw.
    always_comb begin
        out_ok         = s1_valid_q && (s1_mode_q != ST_CAPTURE);
        dout_valid_d   = out_ok;
        dout_sof_d     = out_ok && s1_sof_q;
        dout_d         = dout_q;
        bg_deduct_en_d = bg_deduct_en_q;
        if (out_ok) begin
            if (s1_mode_q == ST_SUBTRACT) begin
                bg_deduct_en_d = 1'b1;
                dout_d         = (s1_din_q >= bg_rd_q) ? (s1_din_q - bg_rd_q) : '0;
            end else begin
                bg_deduct_en_d = 1'b0;
                dout_d         = s1_din_q;
            end
        end
    end

    // Pipeline registers; reset flushes everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_sof_q       <= 1'b0;
            s1_din_q       <= '0;
            s1_mode_q      <= ST_IDLE;
            dout_valid_q   <= 1'b0;
            dout_sof_q     <= 1'b0;
            dout_q         <= '0;
            bg_deduct_en_q <= 1'b0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_sof_q       <= s1_sof_d;
            s1_din_q       <= s1_din_d;
            s1_mode_q      <= s1_mode_d;
            dout_valid_q   <= dout_valid_d;
            dout_sof_q     <= dout_sof_d;
            dout_q         <= dout_d;
            bg_deduct_en_q <= bg_deduct_en_d;
        end
    end

    assign dout_valid   = dout_valid_q;
    assign dout         = dout_q;
    assign dout_sof     = dout_sof_q;
    assign bg_ready     = bg_ready_q;
    assign bg_deduct_en = bg_deduct_en_q;
    assign capturing    = (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_bg_spectrum_subtract.sv
// Directed bench for bg_spectrum_subtract with FFT_LEN=8.
// Each step drives one input cycle; outputs are compared two steps later
// against the expected values supplied with that sample.
module tb_bg_spectrum_subtract;

    logic        clk;
    logic        rst;
    logic        bg_load;
    logic        din_sof;
    logic        din_valid;
    logic [31:0] din;
    logic        dout_valid;
    logic [31:0] dout;
    logic        dout_sof;
    logic        bg_ready;
    logic        bg_deduct_en;
    logic        capturing;

    int n_chk  = 0;
    int n_pass = 0;

    // expected-output pipeline (p1: last step, p2: two steps ago)
    logic        p1_v, p1_sof, p1_ev, p1_en;
    logic [31:0] p1_d;
    logic        p2_v, p2_sof, p2_ev, p2_en;
    logic [31:0] p2_d;
    logic        exp_en;

    int t2_in  [8] = '{12, 3, 5, 100, 6, 4, 5, 7};
    int t2_out [8] = '{7, 0, 0, 95, 1, 0, 0, 2};
    int t4_in  [8] = '{25, 25, 20, 19, 25, 100, 25, 25};
    int t4_out [8] = '{5, 5, 0, 0, 5, 80, 5, 5};

    bg_spectrum_subtract #(
        .DATA_W (32),
        .FFT_LEN(8),
        .ADDR_W (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bg_load     (bg_load),
        .din_sof     (din_sof),
        .din_valid   (din_valid),
        .din         (din),
        .dout_valid  (dout_valid),
        .dout        (dout),
        .dout_sof    (dout_sof),
        .bg_ready    (bg_ready),
        .bg_deduct_en(bg_deduct_en),
        .capturing   (capturing)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        p1_v = 0; p1_sof = 0; p1_ev = 0; p1_en = 0; p1_d = 0;
        p2_v = 0; p2_sof = 0; p2_ev = 0; p2_en = 0; p2_d = 0;
        exp_en = 0;
    endtask

    // Check outputs due this cycle, then drive one input cycle.
    task automatic step(input logic v, input logic sof, input logic [31:0] d, input logic lb,
                        input logic ev, input logic [31:0] ed, input logic een);
        @(negedge clk);
        check_eq("dout_valid", {31'b0, dout_valid}, {31'b0, p2_v & p2_ev});
        if (p2_v && p2_ev) begin
            check_eq("dout", dout, p2_d);
            check_eq("dout_sof", {31'b0, dout_sof}, {31'b0, p2_sof});
            exp_en = p2_en;
        end else begin
            check_eq("dout_sof_idle", {31'b0, dout_sof}, 32'd0);
        end
        check_eq("bg_deduct_en", {31'b0, bg_deduct_en}, {31'b0, exp_en});
        p2_v = p1_v; p2_sof = p1_sof; p2_ev = p1_ev; p2_en = p1_en; p2_d = p1_d;
        p1_v = v; p1_sof = sof; p1_ev = ev; p1_en = een; p1_d = ed;
        din_valid = v;
        din_sof   = sof;
        din       = d;
        bg_load   = lb;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step(0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        rst = 1; bg_load = 0; din_sof = 0; din_valid = 0; din = 0;
        clear_model();
        #3;
        check_eq("rst_dout_valid", {31'b0, dout_valid}, 32'd0);
        check_eq("rst_dout", dout, 32'd0);
        check_eq("rst_bg_ready", {31'b0, bg_ready}, 32'd0);
        check_eq("rst_capturing", {31'b0, capturing}, 32'd0);
        check_eq("rst_bg_deduct_en", {31'b0, bg_deduct_en}, 32'd0);
        @(negedge clk);
        rst = 0;

        // 1: raw pass-through, no background
        for (int i = 0; i < 8; i++) step(1, i == 0, 10 + i, 0, 1, 10 + i, 0);
        idle(2);

        // 2: capture constant background 5, then subtract
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, i == 0, 5, 0, 0, 0, 0);
            check_eq("t2_capturing", {31'b0, capturing}, (i >= 1) ? 32'd1 : 32'd0);
            if (i == 7) check_eq("t2_ready_before_last", {31'b0, bg_ready}, 32'd0);
        end
        idle(1);
        check_eq("t2_capturing_done", {31'b0, capturing}, 32'd0);
        check_eq("t2_bg_ready", {31'b0, bg_ready}, 32'd1);
        for (int i = 0; i < 8; i++) step(1, i == 0, t2_in[i], 0, 1, t2_out[i], 1);
        idle(2);

        // 3: gapped capture of background 1..8, then gapped subtract
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, i == 0, i + 1, 0, 0, 0, 0);
            idle(3);
            check_eq("t3_capturing", {31'b0, capturing}, (i < 7) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1, i == 0, 50, 0, 1, 49 - i, 1);
            idle(3);
        end

        // 4: bg_load at bin 4 does not disturb the current gate
        for (int i = 0; i < 8; i++) step(1, i == 0, 30, i == 4, 1, 29 - i, 1);
        idle(1);
        check_eq("t4_not_capturing", {31'b0, capturing}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1, i == 0, 20, 0, 0, 0, 0);
            if (i == 4) begin
                check_eq("t4_capturing", {31'b0, capturing}, 32'd1);
                check_eq("t4_ready_held", {31'b0, bg_ready}, 32'd1);
            end
        end
        for (int i = 0; i < 8; i++) step(1, i == 0, t4_in[i], 0, 1, t4_out[i], 1);
        idle(2);

        // 6: asynchronous reset in the middle of a subtract gate
        step(1, 1, 25, 0, 1, 5, 1);
        step(1, 0, 25, 0, 1, 5, 1);
        step(1, 0, 25, 0, 1, 5, 1);
        #6;
        check_eq("pre_rst_valid", {31'b0, dout_valid}, 32'd1);
        check_eq("pre_rst_dout", dout, 32'd5);
        rst = 1; din_valid = 0; din_sof = 0;
        #1;
        check_eq("arst_dout_valid", {31'b0, dout_valid}, 32'd0);
        check_eq("arst_bg_ready", {31'b0, bg_ready}, 32'd0);
        check_eq("arst_bg_deduct_en", {31'b0, bg_deduct_en}, 32'd0);
        check_eq("arst_capturing", {31'b0, capturing}, 32'd0);
        @(negedge clk);
        rst = 0;
        clear_model();
        for (int i = 0; i < 8; i++) step(1, i == 0, 25, 0, 1, 25, 0);
        idle(2);

        // 5: capture aborted by sof at bin 5, then a complete capture
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, i == 0, 9, 0, 0, 0, 0);
            if (i >= 1) check_eq("t5_capturing", {31'b0, capturing}, 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            step(1, i == 0, 40 + i, 0, 1, 40 + i, 0);
            if (i == 0) check_eq("t5_capt_before_abort", {31'b0, capturing}, 32'd1);
            if (i == 1) begin
                check_eq("t5_abort_capturing", {31'b0, capturing}, 32'd0);
                check_eq("t5_abort_bg_ready", {31'b0, bg_ready}, 32'd0);
            end
        end
        idle(2);
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, i == 0, 3, 0, 0, 0, 0);
        idle(1);
        check_eq("t5_bg_ready", {31'b0, bg_ready}, 32'd1);
        for (int i = 0; i < 8; i++) step(1, i == 0, 10, 0, 1, 7, 1);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bg_spectrum_subtract.md
Name: bg_spectrum_subtract

Overview:
Background-spectrum subtraction datapath for the accumulated power spectra coming out of the ADQ214 processing chain.
- Captures one range gate of FFT_LEN bins as the noise/background spectrum into on-chip RAM.
- Subtracts that spectrum bin-by-bin from every following gate, saturating at zero.
- Sits directly upstream of the background-deduction control stage:
  - dout_valid drives that stage's data_valid_in.
  - bg_deduct_en drives its BG_Deduction_EN.

Parameters:
DATA_W, 32, width of unsigned accumulated power samples (din, dout, RAM word)
FFT_LEN, 256, bins per range gate; power of two, at least 4
ADDR_W, 8, log2(FFT_LEN); bin counter and RAM address width

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
bg_load  in  1  single-cycle pulse; arms capture of the next full gate as background
din_sof  in  1  qualified by din_valid; marks bin 0 of a gate
din_valid  in  1  input sample strobe; gaps allowed, no backpressure
din  in  DATA_W  unsigned power sample
dout_valid  out  1  output sample strobe
dout  out  DATA_W  background-subtracted sample (or raw, see Behaviour)
dout_sof  out  1  delayed din_sof aligned with dout_valid
bg_ready  out  1  high once a complete background spectrum is stored
bg_deduct_en  out  1  high while output data is background-subtracted
capturing  out  1  high while a background gate is being written

Behaviour:
Reset values:
- All outputs are 0. Bin counter = 0. FSM = IDLE. Armed flag = 0.
- RAM contents are don't-care; bg_ready=0 makes them unused.

Bin counter (ADDR_W bits):
- din_valid & din_sof: current bin = 0; counter <= 1.
- din_valid & !din_sof: current bin = counter; counter <= counter+1, wrapping FFT_LEN-1 -> 0.
- No din_valid: counter holds.

bg_load:
- Pulse sets the armed flag in any state except CAPTURE, where it is ignored.
- bg_load asserted in the same cycle capture begins still counts as consumed; armed stays 0.

FSM:
- IDLE (bg_ready=0): on a bin-0 sample with armed=1 -> CAPTURE; clear armed; write that sample.
- CAPTURE:
  - Each valid sample writes RAM[bin] <= din; capturing=1.
  - After writing bin FFT_LEN-1 -> SUBTRACT; bg_ready <= 1 on the next cycle.
  - din_sof arriving before bin FFT_LEN-1 (short gate): abort to the previous state (IDLE if bg_ready=0, else SUBTRACT); bg_ready keeps its previous value; the new sof sample is processed under that state; armed stays 0.
- SUBTRACT (bg_ready=1): on a bin-0 sample with armed=1 -> CAPTURE (re-capture). bg_ready stays 1 during re-capture.

Datapath, fixed 2-cycle latency from din_valid to dout_valid:
- Stage 1: registered RAM read at bin; din, sof and a mode tag are delayed one cycle.
- Stage 2: output register.
  - Mode SUBTRACT: dout = (din >= bg) ? din-bg : 0.
  - Mode IDLE: dout = din (raw pass-through).
  - Mode CAPTURE: dout_valid suppressed (0) for the whole captured gate.
- bg_deduct_en: registered with dout_valid; 1 for samples tagged SUBTRACT, else 0. It holds its last value between samples, so it stays high across a gate's trailing gap.
- Read/write collision: during CAPTURE no read is used, so none is possible. RAM is simple dual-port, read-first.
- dout_sof = din_sof delayed 2 cycles, gated by dout_valid.

Mid-operation reset:
- Immediately clears bg_ready, capturing, bg_deduct_en and dout_valid.
- Flushes the pipeline. The next gate is passed raw until a new capture completes.

Test Plan:
1. FFT_LEN=8. No bg_load; gate din=10..17 with sof on the first -> dout=10..17, dout_valid 2 cycles after each din_valid, bg_deduct_en=0.
2. bg_load, then gate din=5 (all bins) -> no dout_valid, capturing=1 for 8 samples, bg_ready=1 after the last. Next gate din=12,3,5,100,... -> dout=7,0,0,95,..., bg_deduct_en=1.
3. Background gate with 3-cycle gaps between samples -> capture still completes after exactly 8 valid samples. A subsequent gapped gate gives correct per-bin subtraction, latency 2 cycles per sample.
4. bg_load mid-gate (bin 4) while bg_ready=1 -> bins 4..7 still subtracted with the old background; capture starts at the next sof. New background = 20 -> din=25 yields dout=5.
5. Capture aborted by din_sof at bin 5 -> capturing drops, bg_ready stays 0, the sof gate is passed raw. A second bg_load with a full gate -> bg_ready=1.
6. Assert rst during a SUBTRACT gate -> dout_valid, bg_ready, bg_deduct_en go to 0 asynchronously. After release, the next gate passes raw with bg_deduct_en=0.
